encoder_arbiter: RTL and testbench
==================================

Name: encoder_arbiter

Overview:
- Sequences and multiplexes access to the shared USB packet encoder (ULPI TX path) on behalf of the transaction-layer FSM.
- Two kinds of traffic reach the encoder through this block:
  - handshake packets (ACK/NAK/NYET/STALL) requested by the protocol layer;
  - DATAx packets streamed from the selected endpoint (EP0 control or bulk EP1–EP4).
- It latches the endpoint select and the DATA0/DATA1 PID, locks the encoder to one source until packet completion, and times out stalled endpoints.

Parameters:
- TIMEOUT, 102, cycles to wait for first data beat (IDLE→DATA) or for encoder completion (DONE), before aborting
- TBITS, 7, width of timeout counter; must satisfy TIMEOUT < 2^TBITS

Ports:
- clock  in  1  system clock (ULPI 60 MHz domain)
- reset  in  1  synchronous, active-high reset
- hsk_req_i  in  1  single-cycle request to send a handshake
- hsk_pid_i  in  4  handshake PID, sampled with hsk_req_i
- hsk_done_o  out  1  single-cycle pulse when the handshake has been sent
- snd_req_i  in  1  single-cycle request to send a DATAx packet from the selected EP
- sel_i  in  5  one-hot EP select {ep4..ep0}, sampled with snd_req_i
- ep_parity_i  in  5  per-EP data toggle; 1 = DATA1, 0 = DATA0
- ep_tvalid_i  in  5  per-EP stream valid
- ep_tlast_i  in  5  per-EP stream last
- ep_tdata_i  in  40  per-EP bytes; EPn occupies bits [8n+7:8n]
- ep_tready_o  out  5  per-EP stream ready
- enc_hsk_o  out  1  handshake send strobe to encoder (level)
- enc_tvalid_o  out  1  encoder data valid
- enc_tready_i  in  1  encoder data ready
- enc_tlast_o  out  1  encoder data last
- enc_tdata_o  out  8  encoder data byte
- enc_tpid_o  out  4  PID for the current packet
- enc_sent_i  in  1  encoder pulse: packet (handshake or data) fully transmitted
- busy_o  out  1  high whenever state != IDLE
- sent_o  out  1  single-cycle pulse: DATAx packet completed
- timeout_o  out  1  single-cycle pulse: transaction aborted by timeout
- err_o  out  1  single-cycle pulse: request rejected (bad select, or request while busy)

Behaviour:
- Reset values:
  - all outputs 0; enc_tpid_o = 4'h0;
  - state = IDLE; sel_q = 5'b0; timer = 0.
  - Reset mid-packet aborts immediately, with no sent_o or timeout_o pulse.
- States: one-hot, registered.
  - IDLE
  - HSK: drive handshake
  - DATA: stream from EP
  - DONE: wait for encoder completion
- IDLE, request handling:
  - hsk_req_i → HSK; latch pid_q = hsk_pid_i.
  - snd_req_i with sel_i exactly one-hot → DATA; latch sel_q = sel_i and pid_q.
    - pid_q = 4'b1011 (DATA1) if ep_parity_i[sel] = 1, else 4'b0011 (DATA0).
  - snd_req_i with sel_i zero or multi-hot → stay IDLE; err_o pulses on the next cycle.
  - hsk_req_i and snd_req_i in the same cycle → HSK wins; snd_req is dropped and err_o pulses.
- Request while busy:
  - Any hsk_req_i or snd_req_i received outside IDLE is ignored, and err_o pulses.
- HSK state:
  - enc_hsk_o = 1 and enc_tpid_o = pid_q, held until enc_sent_i.
  - On enc_sent_i → IDLE, with hsk_done_o pulsing the following cycle.
  - No timeout applies.
- DATA state: zero-latency combinational passthrough of the selected source.
  - enc_tvalid_o = ep_tvalid_i[sel_q]
  - enc_tlast_o = ep_tlast_i[sel_q]
  - enc_tdata_o = selected byte
  - ep_tready_o = sel_q & {5{enc_tready_i}}; unselected readies are 0
  - enc_tpid_o = pid_q throughout DATA and DONE.
  - Beat = enc_tvalid_o & enc_tready_i. A beat with tlast → DONE.
  - First-beat timeout:
    - timer increments each cycle until the first beat;
    - at timer == TIMEOUT with no beat → IDLE, timeout_o pulses.
  - After the first beat, the timer is frozen. Underrun protection is the EP's responsibility.
- Zero-length packet:
  - EP presents a single beat with tlast = 1; the encoder discards the data of a ZLP beat.
- DONE state:
  - Wait for enc_sent_i → IDLE, sent_o pulses.
  - timer restarts at 0; reaching TIMEOUT → IDLE, timeout_o pulses.
  - enc_sent_i on the same cycle the timer expires → treat as success (sent_o, no timeout_o).
- Counter width:
  - timer is TBITS wide and saturates at TIMEOUT; it never wraps.
- enc_sent_i received in IDLE or DATA is ignored.
- busy_o = (state != IDLE), registered.

Test Plan:
- Handshake: hsk_req_i, hsk_pid_i = 4'b0010 (ACK) → next cycle enc_hsk_o = 1, enc_tpid_o = 0010. Pulse enc_sent_i after 5 cycles → hsk_done_o pulses once, busy_o returns to 0.
- DATA1 stream: snd_req_i with sel_i = 5'b00100 and ep_parity_i[2] = 1; EP2 streams 4 bytes A1..A4 (tlast on A4) with enc_tready_i toggling 1,0,1,… → enc_tdata_o carries A1..A4 in order, enc_tpid_o = 1011, ep_tready_o[4,3,1,0] stay 0. enc_sent_i → sent_o pulses.
- First-beat timeout: snd_req_i with sel_i = 5'b00010, EP1 tvalid held at 0 → timeout_o pulses exactly TIMEOUT+1 cycles after the request, state returns to IDLE, no sent_o.
- Bad/colliding requests: (a) snd_req_i with sel_i = 5'b00011 → err_o pulses, busy_o stays 0. (b) hsk_req_i and snd_req_i in the same cycle → HSK is entered and err_o pulses. (c) snd_req_i during HSK → ignored, err_o pulses.
- ZLP on EP0: sel_i = 5'b00001, ep_parity_i[0] = 0, a single beat with tlast → enc_tpid_o = 0011, DONE entered after 1 beat. enc_sent_i on the same cycle the DONE timer expires → sent_o pulses, no timeout_o.
- Reset mid-packet: assert reset after 2 of 8 beats → all outputs 0 the next cycle; a fresh snd_req_i afterwards completes normally.

Source files
------------

// File: rtl/encoder_arbiter.sv
// ---------------------------------------------------------------------------
// encoder_arbiter
//
// Gives the transaction-layer FSM a single point of access to the shared USB
// packet encoder (ULPI TX path). It carries two kinds of traffic:
//   - handshake packets (ACK/NAK/NYET/STALL), and
//   - DATAx packets streamed from one of EP0..EP4.
// The endpoint select and the DATA0/DATA1 PID are latched when the request
// is accepted. The encoder then stays locked to that source until the packet
// completes. An endpoint that never starts streaming, or an encoder that never
// reports completion, causes a timeout abort.
//
// Ports
//   clock, reset           system clock, synchronous active-high reset
//   hsk_req_i/hsk_pid_i    handshake request (1 cycle) and its PID
//   hsk_done_o             pulse: handshake transmitted
//   snd_req_i/sel_i        DATAx request (1 cycle), one-hot EP select {ep4..ep0}
//   ep_parity_i            per-EP data toggle (1 = DATA1)
//   ep_tvalid_i/tlast_i/tdata_i/tready_o   per-EP streams, EPn byte at [8n+7:8n]
//   enc_hsk_o              handshake strobe to encoder (level)
//   enc_tvalid_o/tready_i/tlast_o/tdata_o  stream towards encoder
//   enc_tpid_o             PID of the current packet
//   enc_sent_i             encoder pulse: packet fully transmitted
//   busy_o                 arbiter is not idle
//   sent_o                 pulse: DATAx packet completed
//   timeout_o              pulse: transaction aborted by timeout
//   err_o                  pulse: request rejected
// ---------------------------------------------------------------------------
module encoder_arbiter #(
    parameter int TIMEOUT = 102,
    parameter int TBITS   = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hsk_req_i,
    input  logic [3:0]  hsk_pid_i,
    output logic        hsk_done_o,
    input  logic        snd_req_i,
    input  logic [4:0]  sel_i,
    input  logic [4:0]  ep_parity_i,
    input  logic [4:0]  ep_tvalid_i,
    input  logic [4:0]  ep_tlast_i,
    input  logic [39:0] ep_tdata_i,
    output logic [4:0]  ep_tready_o,
    output logic        enc_hsk_o,
    output logic        enc_tvalid_o,
    input  logic        enc_tready_i,
    output logic        enc_tlast_o,
    output logic [7:0]  enc_tdata_o,
    output logic [3:0]  enc_tpid_o,
    input  logic        enc_sent_i,
    output logic        busy_o,
    output logic        sent_o,
    output logic        timeout_o,
    output logic        err_o
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        HSK  = 4'b0010,
        DATA = 4'b0100,
        DONE = 4'b1000
    } state_t;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    state_t           state, state_nxt;
    logic [4:0]       sel_q;
    logic [3:0]       pid_q;
    logic [TBITS-1:0] timer;
    logic             first_q;      // a beat has been seen in this DATA phase

    logic hsk_done_q, sent_q, timeout_q, err_q;
    logic hsk_done_nxt, sent_nxt, timeout_nxt, err_nxt;
    logic load_hsk, load_snd, timer_clr, timer_inc;
    logic sel_onehot, timer_hit, beat;

    assign sel_onehot = (sel_i != 5'd0) && ((sel_i & (sel_i - 5'd1)) == 5'd0);
    assign timer_hit  = (timer == TBITS'(TIMEOUT));

    // Encoder-side mux: only the state decides who owns the encoder.
    always_comb begin
        enc_hsk_o    = 1'b0;
        enc_tvalid_o = 1'b0;
        enc_tlast_o  = 1'b0;
        enc_tdata_o  = 8'd0;
        enc_tpid_o   = 4'h0;
        ep_tready_o  = 5'd0;
        unique case (state)
            HSK: begin
                enc_hsk_o  = 1'b1;
                enc_tpid_o = pid_q;
            end
            DATA: begin
                enc_tvalid_o = |(ep_tvalid_i & sel_q);
                enc_tlast_o  = |(ep_tlast_i & sel_q);
                for (int j = 0; j < 5; j++) begin
                    enc_tdata_o = enc_tdata_o | (ep_tdata_i[8*j +: 8] & {8{sel_q[j]}});
                end
                ep_tready_o  = sel_q & {5{enc_tready_i}};
                enc_tpid_o   = pid_q;
            end
            DONE: begin
                enc_tpid_o = pid_q;
            end
            default: ;
        endcase
    end

    assign beat = enc_tvalid_o & enc_tready_i;

    // Next-state and pulse generation
    always_comb begin
        state_nxt    = state;
        load_hsk     = 1'b0;
        load_snd     = 1'b0;
        timer_clr    = 1'b0;
        timer_inc    = 1'b0;
        hsk_done_nxt = 1'b0;
        sent_nxt     = 1'b0;
        timeout_nxt  = 1'b0;
        err_nxt      = 1'b0;
        unique case (state)
            IDLE: begin
                if (hsk_req_i) begin
                    // Handshake wins a collision; the dropped send is reported.
                    state_nxt = HSK;
                    load_hsk  = 1'b1;
                    err_nxt   = snd_req_i;
                end else if (snd_req_i) begin
                    if (sel_onehot) begin
                        state_nxt = DATA;
                        load_snd  = 1'b1;
                        timer_clr = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            HSK: begin
                err_nxt = hsk_req_i | snd_req_i;
                if (enc_sent_i) begin
                    state_nxt    = IDLE;
                    hsk_done_nxt = 1'b1;
                end
            end
            DATA: begin
                err_nxt = hsk_req_i | snd_req_i;
                if (beat && enc_tlast_o) begin
                    state_nxt = DONE;
                    timer_clr = 1'b1;
                end else if (!first_q && !beat) begin
                    if (timer_hit) begin
                        state_nxt   = IDLE;
                        timeout_nxt = 1'b1;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                err_nxt = hsk_req_i | snd_req_i;
                // Completion on the expiry cycle still counts as success.
                if (enc_sent_i) begin
                    state_nxt = IDLE;
                    sent_nxt  = 1'b1;
                end else if (timer_hit) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sel_q      <= 5'd0;
            timer      <= '0;
            first_q    <= 1'b0;
            hsk_done_q <= 1'b0;
            sent_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            hsk_done_q <= hsk_done_nxt;
            sent_q     <= sent_nxt;
            timeout_q  <= timeout_nxt;
            err_q      <= err_nxt;
            if (load_snd) begin
                sel_q <= sel_i;
            end
            if (load_snd) begin
                first_q <= 1'b0;
            end else if (beat) begin
                first_q <= 1'b1;
            end
            // Timer saturates at TIMEOUT and never wraps.
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc && !timer_hit) begin
                timer <= timer + TBITS'(1);
            end
        end
    end

    // PID latch is data only; outputs are gated by state, so no reset needed.
    always_ff @(posedge clock) begin
        if (load_hsk) begin
            pid_q <= hsk_pid_i;
        end else if (load_snd) begin
            pid_q <= (|(ep_parity_i & sel_i)) ? PID_DATA1 : PID_DATA0;
        end
    end

    assign busy_o     = (state != IDLE);
    assign hsk_done_o = hsk_done_q;
    assign sent_o     = sent_q;
    assign timeout_o  = timeout_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_encoder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_encoder_arbiter
//
// Directed sequence with randomized payloads, endpoints, parities, ready
// patterns and completion delays. Expected bytes come from a per-packet queue,
// expected PIDs from the DATA0/DATA1 toggle rule, and expected pulse timing
// from cycle counts relative to the request / last beat.
// ---------------------------------------------------------------------------
module tb_encoder_arbiter;

    localparam int TIMEOUT = 102;
    localparam int TBITS   = 7;

    logic        clock = 1'b0;
    logic        reset;
    logic        hsk_req_i;
    logic [3:0]  hsk_pid_i;
    logic        hsk_done_o;
    logic        snd_req_i;
    logic [4:0]  sel_i;
    logic [4:0]  ep_parity_i;
    logic [4:0]  ep_tvalid_i;
    logic [4:0]  ep_tlast_i;
    logic [39:0] ep_tdata_i;
    logic [4:0]  ep_tready_o;
    logic        enc_hsk_o;
    logic        enc_tvalid_o;
    logic        enc_tready_i;
    logic        enc_tlast_o;
    logic [7:0]  enc_tdata_o;
    logic [3:0]  enc_tpid_o;
    logic        enc_sent_i;
    logic        busy_o;
    logic        sent_o;
    logic        timeout_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;
    logic [7:0] pkt[$];

    encoder_arbiter #(.TIMEOUT(TIMEOUT), .TBITS(TBITS)) dut (
        .clock(clock), .reset(reset),
        .hsk_req_i(hsk_req_i), .hsk_pid_i(hsk_pid_i), .hsk_done_o(hsk_done_o),
        .snd_req_i(snd_req_i), .sel_i(sel_i), .ep_parity_i(ep_parity_i),
        .ep_tvalid_i(ep_tvalid_i), .ep_tlast_i(ep_tlast_i), .ep_tdata_i(ep_tdata_i),
        .ep_tready_o(ep_tready_o),
        .enc_hsk_o(enc_hsk_o), .enc_tvalid_o(enc_tvalid_o), .enc_tready_i(enc_tready_i),
        .enc_tlast_o(enc_tlast_o), .enc_tdata_o(enc_tdata_o), .enc_tpid_o(enc_tpid_o),
        .enc_sent_i(enc_sent_i),
        .busy_o(busy_o), .sent_o(sent_o), .timeout_o(timeout_o), .err_o(err_o)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        hsk_req_i    = 1'b0;
        hsk_pid_i    = 4'h0;
        snd_req_i    = 1'b0;
        sel_i        = 5'd0;
        ep_tvalid_i  = 5'd0;
        ep_tlast_i   = 5'd0;
        enc_sent_i   = 1'b0;
        enc_tready_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},    40'(busy_o), 40'd0);
        chk({tag, "_hsk"},     40'(enc_hsk_o), 40'd0);
        chk({tag, "_tvalid"},  40'(enc_tvalid_o), 40'd0);
        chk({tag, "_tready"},  40'(ep_tready_o), 40'd0);
        chk({tag, "_tpid"},    40'(enc_tpid_o), 40'd0);
        chk({tag, "_sent"},    40'(sent_o), 40'd0);
        chk({tag, "_timeout"}, 40'(timeout_o), 40'd0);
        chk({tag, "_err"},     40'(err_o), 40'd0);
        chk({tag, "_hdone"},   40'(hsk_done_o), 40'd0);
    endtask

    // Handshake: request, hold for 'hold' cycles, then completion.
    task automatic send_hsk(input logic [3:0] pid, input int hold);
        step();
        hsk_req_i = 1'b1;
        hsk_pid_i = pid;
        step();
        hsk_req_i = 1'b0;
        hsk_pid_i = 4'h0;
        #1;
        for (int k = 0; k < hold; k++) begin
            chk("hsk_strobe", 40'(enc_hsk_o), 40'd1);
            chk("hsk_pid",    40'(enc_tpid_o), 40'(pid));
            chk("hsk_busy",   40'(busy_o), 40'd1);
            step();
        end
        enc_sent_i = 1'b1;
        step();
        enc_sent_i = 1'b0;
        #1;
        chk("hsk_done", 40'(hsk_done_o), 40'd1);
        chk("hsk_busy_end", 40'(busy_o), 40'd0);
        chk("hsk_strobe_end", 40'(enc_hsk_o), 40'd0);
        step();
        chk("hsk_done_once", 40'(hsk_done_o), 40'd0);
    endtask

    // DATAx packet from 'ep' with contents of pkt. mode: 0 random valid/ready,
    // 1 always valid/ready, 2 valid with ready toggling 1,0,1,...
    // sent_delay: edge (counted from last beat) at which enc_sent_i is seen.
    // abort_beats != 0: return right after that many beats have been accepted.
    task automatic send_packet(input int ep, input bit par, input int sent_delay,
                               input int abort_beats, input int mode);
        logic [3:0] exp_pid;
        logic [4:0] sel1;
        int n, idx, cyc;
        logic v, r;
        n       = pkt.size();
        exp_pid = par ? 4'b1011 : 4'b0011;
        sel1    = 5'(1 << ep);
        step();
        snd_req_i   = 1'b1;
        sel_i       = sel1;
        ep_parity_i = 5'($urandom);
        ep_parity_i[ep] = par;
        step();
        snd_req_i = 1'b0;
        #1;
        chk("req_busy", 40'(busy_o), 40'd1);
        chk("req_err",  40'(err_o), 40'd0);
        idx = 0;
        cyc = 0;
        while (idx < n) begin
            if (cyc > 300) begin
                tests++;
                fails++;
                $display("FAIL data_bound observed=%0d beats expected=%0d", idx, n);
                return;
            end
            if (mode == 1)      begin v = 1'b1; r = 1'b1; end
            else if (mode == 2) begin v = 1'b1; r = (cyc % 2 == 0); end
            else begin
                v = (cyc > 40) ? 1'b1 : 1'($urandom_range(0, 1));
                r = (cyc > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            ep_tvalid_i = 5'($urandom);
            ep_tvalid_i[ep] = v;
            ep_tlast_i = 5'($urandom);
            ep_tlast_i[ep] = (idx == n - 1);
            for (int j = 0; j < 5; j++) begin
                ep_tdata_i[8*j +: 8] = (j == ep) ? pkt[idx] : 8'($urandom);
            end
            enc_tready_i = r;
            #1;
            chk("d_tvalid", 40'(enc_tvalid_o), 40'(v));
            chk("d_tlast",  40'(enc_tlast_o), 40'(idx == n - 1));
            chk("d_tready", 40'(ep_tready_o), 40'(sel1 & {5{r}}));
            chk("d_tpid",   40'(enc_tpid_o), 40'(exp_pid));
            if (v) chk("d_tdata", 40'(enc_tdata_o), 40'(pkt[idx]));
            step();
            if (v && r) idx++;
            cyc++;
            if (abort_beats != 0 && idx == abort_beats) return;
        end
        ep_tvalid_i  = 5'd0;
        ep_tlast_i   = 5'd0;
        enc_tready_i = 1'b1;
        #1;
        chk("done_tvalid", 40'(enc_tvalid_o), 40'd0);
        chk("done_tready", 40'(ep_tready_o), 40'd0);
        chk("done_busy",   40'(busy_o), 40'd1);
        chk("done_tpid",   40'(enc_tpid_o), 40'(exp_pid));
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            enc_sent_i = (k == sent_delay);
            step();
            enc_sent_i = 1'b0;
            if (k == sent_delay) begin
                chk("done_sent",    40'(sent_o), 40'd1);
                chk("done_no_tmo",  40'(timeout_o), 40'd0);
                chk("done_idle",    40'(busy_o), 40'd0);
                break;
            end else if (k == TIMEOUT + 1) begin
                chk("done_tmo",     40'(timeout_o), 40'd1);
                chk("done_no_sent", 40'(sent_o), 40'd0);
                chk("done_idle_t",  40'(busy_o), 40'd0);
            end else begin
                chk("done_wait_busy", 40'(busy_o), 40'd1);
                chk("done_wait_sent", 40'(sent_o), 40'd0);
                chk("done_wait_tmo",  40'(timeout_o), 40'd0);
            end
        end
        step();
        chk("post_sent_clear", 40'(sent_o), 40'd0);
        chk("post_tmo_clear",  40'(timeout_o), 40'd0);
    endtask

    initial begin
        int ep, n;
        quiet();
        ep_parity_i = 5'd0;
        ep_tdata_i  = 40'd0;
        // Reset, with noise on the request inputs.
        reset = 1'b1;
        hsk_req_i = 1'b1;
        snd_req_i = 1'b1;
        sel_i = 5'b00100;
        repeat (2) step();
        quiet();
        enc_tready_i = 1'b1;
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        step();
        check_idle_outputs("post_reset");

        // Handshakes: ACK first, then random PIDs and hold lengths.
        send_hsk(4'b0010, 5);
        for (int i = 0; i < 3; i++) send_hsk(4'($urandom), $urandom_range(1, 8));

        // DATA1 on EP2, A1..A4, ready toggling.
        pkt = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_packet(2, 1'b1, 3, 0, 2);

        // First-beat timeout on EP1.
        step();
        snd_req_i = 1'b1;
        sel_i = 5'b00010;
        ep_tvalid_i = 5'd0;
        step();
        snd_req_i = 1'b0;
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            enc_tready_i = 1'($urandom);
            step();
            chk("fb_tmo",  40'(timeout_o), 40'(k == TIMEOUT + 1));
            chk("fb_busy", 40'(busy_o), 40'(k <= TIMEOUT));
        end
        chk("fb_no_sent", 40'(sent_o), 40'd0);
        step();
        chk("fb_tmo_once", 40'(timeout_o), 40'd0);

        // (a) multi-hot select.
        snd_req_i = 1'b1;
        sel_i = 5'b00011;
        step();
        snd_req_i = 1'b0;
        chk("bad_sel_err",  40'(err_o), 40'd1);
        chk("bad_sel_busy", 40'(busy_o), 40'd0);
        // zero select
        snd_req_i = 1'b1;
        sel_i = 5'b00000;
        step();
        snd_req_i = 1'b0;
        chk("zero_sel_err",  40'(err_o), 40'd1);
        chk("zero_sel_busy", 40'(busy_o), 40'd0);
        step();
        chk("err_once", 40'(err_o), 40'd0);
        // (b) collision: handshake wins.
        hsk_req_i = 1'b1;
        hsk_pid_i = 4'b1010;
        snd_req_i = 1'b1;
        sel_i = 5'b00100;
        step();
        hsk_req_i = 1'b0;
        snd_req_i = 1'b0;
        chk("coll_hsk",  40'(enc_hsk_o), 40'd1);
        chk("coll_pid",  40'(enc_tpid_o), 40'hA);
        chk("coll_err",  40'(err_o), 40'd1);
        step();
        chk("coll_err_once", 40'(err_o), 40'd0);
        // (c) send request while in HSK.
        snd_req_i = 1'b1;
        sel_i = 5'b00001;
        step();
        snd_req_i = 1'b0;
        chk("busy_req_err", 40'(err_o), 40'd1);
        chk("busy_req_hsk", 40'(enc_hsk_o), 40'd1);
        chk("busy_req_tv",  40'(enc_tvalid_o), 40'd0);
        enc_sent_i = 1'b1;
        step();
        enc_sent_i = 1'b0;
        chk("busy_req_done", 40'(hsk_done_o), 40'd1);
        chk("busy_req_idle", 40'(busy_o), 40'd0);

        // ZLP on EP0, completion exactly on the expiry cycle.
        pkt = '{8'($urandom)};
        send_packet(0, 1'b0, TIMEOUT + 1, 0, 1);

        // Encoder never completes: DONE timeout.
        pkt = '{8'h11, 8'h22};
        send_packet(4, 1'b1, TIMEOUT + 10, 0, 1);

        // Reset after 2 of 8 beats.
        pkt.delete();
        for (int i = 0; i < 8; i++) pkt.push_back(8'($urandom));
        send_packet(3, 1'b1, 1, 2, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        quiet();
        step();
        chk("mid_reset_no_sent", 40'(sent_o), 40'd0);
        chk("mid_reset_no_tmo",  40'(timeout_o), 40'd0);
        send_packet(3, 1'b0, 2, 0, 1);

        // Randomized packets.
        for (int i = 0; i < 8; i++) begin
            ep = $urandom_range(0, 4);
            n  = $urandom_range(1, 8);
            pkt.delete();
            for (int b = 0; b < n; b++) pkt.push_back(8'($urandom));
            send_packet(ep, 1'($urandom), $urandom_range(1, 20), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
